// File: rtl/write_drain.sv
// Write drain: pops entries from a write-buffer head and replays them as
// AXI write bursts (AW, then len+1 W beats, then the B response).
// The first entry presented in IDLE defines the burst address/control;
// only data and strobes of the entries that follow are used.
module write_drain #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    // Head of the write buffer
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [ID_WIDTH-1:0]       in_id,
    input  logic [1:0]                in_burst,
    input  logic [2:0]                in_size,
    input  logic [7:0]                in_len,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [DATA_WIDTH/8-1:0]   in_strb,
    input  logic                      in_valid,
    output logic                      in_ready,

    // AXI write address channel
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [ID_WIDTH-1:0]       awid,
    output logic [1:0]                awburst,
    output logic [2:0]                awsize,
    output logic [7:0]                awlen,
    output logic                      awvalid,
    input  logic                      awready,

    // AXI write data channel
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,

    // AXI write response channel
    input  logic [ID_WIDTH-1:0]       bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,

    // Status
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                last_bresp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    // A response is bad when it is SLVERR/DECERR or carries a foreign ID.
    function automatic logic resp_is_error(
        input logic [1:0]          resp,
        input logic [ID_WIDTH-1:0] resp_id,
        input logic [ID_WIDTH-1:0] burst_id
    );
        return resp[1] | (resp_id != burst_id);
    endfunction

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   aw_addr_r;
    logic [ID_WIDTH-1:0]     aw_id_r;
    logic [1:0]              aw_burst_r;
    logic [2:0]              aw_size_r;
    logic [7:0]              aw_len_r;
    logic [7:0]              beat_cnt_r;
    logic [1:0]              last_bresp_r;
    logic                    done_r;
    logic                    err_r;

    logic                    in_addr_phase_s;
    logic                    in_data_phase_s;
    logic                    in_resp_phase_s;
    logic                    last_beat_s;
    logic                    w_fire_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic [STRB_WIDTH-1:0]   wstrb_s;

    // Decode the state register into per-phase qualifiers and the W datapath.
    always_comb begin
        in_addr_phase_s = 1'b0;
        in_data_phase_s = 1'b0;
        in_resp_phase_s = 1'b0;
        case (state_r)
            IDLE:    in_addr_phase_s = 1'b0;
            ADDR:    in_addr_phase_s = 1'b1;
            DATA:    in_data_phase_s = 1'b1;
            RESP:    in_resp_phase_s = 1'b1;
            default: in_addr_phase_s = 1'b0;
        endcase

        // beat_cnt only reaches len on the final beat, so 256-beat bursts never wrap early
        last_beat_s = in_data_phase_s && (beat_cnt_r == aw_len_r);
        w_fire_s    = in_data_phase_s && in_valid && wready;

        // Keep the W bus quiet outside DATA so idle/reset outputs are all zero
        if (in_data_phase_s) begin
            wdata_s = in_data;
            wstrb_s = in_strb;
        end else begin
            wdata_s = {DATA_WIDTH{1'b0}};
            wstrb_s = {STRB_WIDTH{1'b0}};
        end
    end

    // Burst sequencer: latch head entry, AW handshake, count W beats, take B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            aw_addr_r    <= {ADDR_WIDTH{1'b0}};
            aw_id_r      <= {ID_WIDTH{1'b0}};
            aw_burst_r   <= 2'b00;
            aw_size_r    <= 3'b000;
            aw_len_r     <= 8'd0;
            beat_cnt_r   <= 8'd0;
            last_bresp_r <= 2'b00;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            // done/err are single-cycle pulses
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Latch only; the head entry is popped later as the first W beat
                    if (in_valid) begin
                        aw_addr_r  <= in_addr;
                        aw_id_r    <= in_id;
                        aw_burst_r <= in_burst;
                        aw_size_r  <= in_size;
                        aw_len_r   <= in_len;
                        state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (awready) begin
                        beat_cnt_r <= 8'd0;
                        state_r    <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire_s) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        if (last_beat_s) begin
                            state_r <= RESP;
                        end
                    end
                end
                RESP: begin
                    // Returning to IDLE here means no new latch until next cycle
                    if (bvalid) begin
                        last_bresp_r <= bresp;
                        done_r       <= 1'b1;
                        err_r        <= resp_is_error(bresp, bid, aw_id_r);
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign awaddr     = aw_addr_r;
    assign awid       = aw_id_r;
    assign awburst    = aw_burst_r;
    assign awsize     = aw_size_r;
    assign awlen      = aw_len_r;
    assign awvalid    = in_addr_phase_s;

    assign wdata      = wdata_s;
    assign wstrb      = wstrb_s;
    assign wlast      = last_beat_s;
    assign wvalid     = in_data_phase_s && in_valid;
    assign in_ready   = in_data_phase_s && wready;

    assign bready     = in_resp_phase_s;

    assign busy       = (state_r != IDLE);
    assign done       = done_r;
    assign err        = err_r;
    assign last_bresp = last_bresp_r;

endmodule

// File: tb/tb_write_drain.sv
// Directed bench for write_drain: a table of burst scenarios replayed
// through one burst driver, plus a hand-written mid-burst reset sequence.
module tb_write_drain;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] in_addr;
    logic [IW-1:0] in_id;
    logic [1:0]    in_burst;
    logic [2:0]    in_size;
    logic [7:0]    in_len;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_strb;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] awaddr;
    logic [IW-1:0] awid;
    logic [1:0]    awburst;
    logic [2:0]    awsize;
    logic [7:0]    awlen;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    last_bresp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    write_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_addr(in_addr), .in_id(in_id), .in_burst(in_burst), .in_size(in_size),
        .in_len(in_len), .in_data(in_data), .in_strb(in_strb),
        .in_valid(in_valid), .in_ready(in_ready),
        .awaddr(awaddr), .awid(awid), .awburst(awburst), .awsize(awsize),
        .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy(busy), .done(done), .err(err), .last_bresp(last_bresp)
    );

    typedef struct {
        logic [7:0]    len;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [1:0]    bresp;
        logic [IW-1:0] bid;
        int            aw_wait;
        bit            wtoggle;
        bit            stall;
        logic [DW-1:0] base;
        logic          exp_err;
        logic [1:0]    exp_bresp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input vec_t v);
        int k, cyc, pops, lasts, stall_cnt;
        bit w, stalled;
        logic [SW-1:0] exp_strb;
        // IDLE: present head entry; nothing may be popped or requested yet
        awready  = 1'b0;
        wready   = 1'b1;
        bvalid   = 1'b0;
        in_valid = 1'b1;
        in_addr  = v.addr;
        in_id    = v.id;
        in_burst = 2'b01;
        in_size  = 3'd3;
        in_len   = v.len;
        in_data  = v.base;
        in_strb  = ~8'(0);
        #1;
        chk("idle_awvalid", awvalid, 1'b0);
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_busy", busy, 1'b0);
        step();
        // ADDR: fields must hold while awready is withheld
        for (int i = 0; i <= v.aw_wait; i++) begin
            awready = (i == v.aw_wait);
            #1;
            chk("aw_valid", awvalid, 1'b1);
            chk("aw_addr", awaddr, v.addr);
            chk("aw_id", awid, v.id);
            chk("aw_len", awlen, v.len);
            chk("aw_burst", awburst, 2'b01);
            chk("aw_size", awsize, 3'd3);
            chk("aw_no_pop", in_ready, 1'b0);
            chk("aw_no_wvalid", wvalid, 1'b0);
            step();
        end
        awready = 1'b0;
        // DATA: one pop per accepted beat, wlast only on beat len
        k = 0; cyc = 0; pops = 0; lasts = 0; stall_cnt = 0;
        while (k <= int'(v.len) && cyc < 2000) begin
            w        = v.wtoggle ? (cyc % 2 == 0) : 1'b1;
            stalled  = v.stall && (k == 1) && (stall_cnt < 2);
            in_valid = !stalled;
            wready   = w;
            in_data  = v.base + 64'(k);
            exp_strb = ~8'(k);
            in_strb  = exp_strb;
            if (k > 0) begin
                in_addr = ~v.addr;
                in_id   = ~v.id;
                in_len  = 8'd7;
            end
            #1;
            if (stalled) begin
                chk("stall_wvalid", wvalid, 1'b0);
                chk("stall_in_ready_gated", in_ready & in_valid, 1'b0);
                chk("stall_busy", busy, 1'b1);
                chk("stall_wlast", wlast, (k == int'(v.len)));
                stall_cnt++;
            end else begin
                chk("w_valid", wvalid, 1'b1);
                chk("w_data", wdata, v.base + 64'(k));
                chk("w_strb", wstrb, exp_strb);
                chk("w_last", wlast, (k == int'(v.len)));
                chk("w_in_ready", in_ready, w);
                chk("w_awvalid", awvalid, 1'b0);
                if (in_valid && in_ready) pops++;
                if (w) begin
                    if (wlast) lasts++;
                    k++;
                end
            end
            step();
            cyc++;
        end
        chk("beats_done", k, int'(v.len) + 1);
        chk("pop_count", pops, int'(v.len) + 1);
        chk("wlast_count", lasts, 1);
        in_valid = 1'b0;
        wready   = 1'b1;
        // RESP: bready high, nothing reported until B arrives
        #1;
        chk("resp_bready", bready, 1'b1);
        chk("resp_busy", busy, 1'b1);
        chk("resp_wvalid", wvalid, 1'b0);
        chk("resp_in_ready", in_ready, 1'b0);
        step();
        bvalid = 1'b1;
        bresp  = v.bresp;
        bid    = v.bid;
        #1;
        chk("resp_done_early", done, 1'b0);
        chk("resp_bready2", bready, 1'b1);
        step();
        bvalid = 1'b0;
        bresp  = 2'b00;
        bid    = '0;
        #1;
        chk("done_pulse", done, 1'b1);
        chk("err_pulse", err, v.exp_err);
        chk("last_bresp", last_bresp, v.exp_bresp);
        chk("idle_after_busy", busy, 1'b0);
        chk("idle_after_bready", bready, 1'b0);
        step();
        chk("done_clear", done, 1'b0);
        chk("err_clear", err, 1'b0);
        chk("last_bresp_hold", last_bresp, v.exp_bresp);
    endtask

    initial begin
        //          len    addr          id     bresp  bid    wait tog stall base         err   bresp
        vecs[0] = '{8'd0,   32'h0000_1000, 4'd3, 2'b00, 4'd3, 0, 1'b0, 1'b0, 64'h55,      1'b0, 2'b00};
        vecs[1] = '{8'd3,   32'h0000_2000, 4'd3, 2'b00, 4'd3, 0, 1'b0, 1'b0, 64'hA,       1'b0, 2'b00};
        vecs[2] = '{8'd2,   32'h0000_3000, 4'd3, 2'b10, 4'd3, 0, 1'b0, 1'b0, 64'h100,     1'b1, 2'b10};
        vecs[3] = '{8'd1,   32'h0000_4000, 4'd3, 2'b00, 4'd5, 0, 1'b0, 1'b0, 64'h200,     1'b1, 2'b00};
        vecs[4] = '{8'd5,   32'hDEAD_BEE0, 4'd9, 2'b00, 4'd9, 5, 1'b1, 1'b1, 64'hF0F0_0000, 1'b0, 2'b00};
        vecs[5] = '{8'd255, 32'h8000_0000, 4'd1, 2'b01, 4'd1, 1, 1'b0, 1'b0, 64'h1_0000,  1'b0, 2'b01};

        rst_n = 1'b0;
        in_addr = '0; in_id = '0; in_burst = '0; in_size = '0; in_len = '0;
        in_data = '0; in_strb = '0; in_valid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_last_bresp", last_bresp, 2'b00);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
        end

        // Mid-burst reset: two of four beats sent, then reset with head still valid
        in_valid = 1'b1; in_addr = 32'h0000_5000; in_id = 4'd6; in_len = 8'd3;
        in_burst = 2'b01; in_size = 3'd3; in_data = 64'h77; in_strb = 8'hFF;
        wready = 1'b0;
        step();
        awready = 1'b1;
        step();
        awready = 1'b0;
        wready  = 1'b1;
        step();
        step();
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_last_bresp", last_bresp, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_awvalid", awvalid, 1'b0);
        chk("mr_awaddr", awaddr, 32'd0);
        chk("mr_awlen", awlen, 8'd0);
        chk("mr_awid", awid, 4'd0);
        chk("mr_wvalid", wvalid, 1'b0);
        chk("mr_wlast", wlast, 1'b0);
        chk("mr_wdata", wdata, 64'd0);
        chk("mr_in_ready", in_ready, 1'b0);
        chk("mr_bready", bready, 1'b0);
        chk("mr_done", done, 1'b0);
        chk("mr_err", err, 1'b0);
        chk("mr_last_bresp", last_bresp, 2'b00);
        step();
        chk("mr_hold_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", busy, 1'b0);
        run_burst(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
